// File: rtl/esn_pe_pkg.sv
// esn_pe_pkg: shared PE geometry defaults, frame length, mode encodings and feeder states
package esn_pe_pkg;
  localparam int WORD_LEN_DEF = 16;
  localparam int NEU_IN_DEF = 8;
  localparam int NEU_OUT_DEF = 4;
  localparam int FRAME_LEN = NEU_IN_DEF + NEU_IN_DEF * NEU_OUT_DEF;
  localparam logic [1:0] MODE_WUPD = 2'b00;
  localparam logic [1:0] MODE_MVM = 2'b01;
  typedef enum logic [2:0] {IDLE, LOAD_D, LOAD_W, FIRE, SETTLE} state_t;
endpackage

// File: rtl/pe_feeder.sv
// pe_feeder: packs a word stream into PE D/W vectors and fires the PE once per frame; PE_FEEDER_WEIGHT_REUSE_EN adds weight_keep to skip reloading W
module pe_feeder
  import esn_pe_pkg::*;
#(
  parameter int WORD_LEN = WORD_LEN_DEF,
  parameter int NEU_IN = NEU_IN_DEF,
  parameter int NEU_OUT = NEU_OUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic [WORD_LEN-1:0] in_data,
  input  logic [1:0] mode_in,
`ifdef PE_FEEDER_WEIGHT_REUSE_EN
  input  logic weight_keep,
`endif
  output logic [WORD_LEN*NEU_IN-1:0] D,
  output logic [WORD_LEN*NEU_IN*NEU_OUT-1:0] W,
  output logic ce,
  output logic [1:0] mode,
  output logic q_valid
);
  localparam int NW = NEU_IN * NEU_OUT;
  localparam int CW = NW > 1 ? $clog2(NW) : 1;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic xfer, first, keep;
  assign xfer = in_valid && in_ready;
  assign first = xfer && state == LOAD_D && cnt == '0;
`ifdef PE_FEEDER_WEIGHT_REUSE_EN
  logic keep_r;
  // weight_keep is captured with the frame's first neuron word and held for the rest of LOAD_D
  always_ff @(posedge clk or posedge rst)
    if (rst) keep_r <= 1'b0;
    else if (first) keep_r <= weight_keep;
  assign keep = cnt == '0 ? weight_keep : keep_r;
`else
  assign keep = 1'b0;
`endif
  // state register and the shared word counter, which restarts on every state change
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= state_n != state ? '0 : cnt + CW'(xfer);
    end
  // frame sequencing: neurons, then synapses (unless reused), one fire cycle, one settle cycle
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: state_n = LOAD_D;
      LOAD_D: if (xfer && cnt == CW'(NEU_IN - 1)) state_n = keep ? FIRE : LOAD_W;
      LOAD_W: if (xfer && cnt == CW'(NW - 1)) state_n = FIRE;
      FIRE: state_n = SETTLE;
      SETTLE: state_n = LOAD_D;
      default: state_n = IDLE;
    endcase
  end
  // handshake and PE strobes decode straight from the state so reset clears them at once
  always_comb begin
    in_ready = state == LOAD_D || state == LOAD_W;
    ce = state == FIRE;
    q_valid = state == SETTLE;
  end
  // operand capture: each accepted word lands in the slot named by the counter; mode follows word 0
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      D <= '0;
      W <= '0;
      mode <= MODE_MVM;
    end else if (xfer) begin
      if (state == LOAD_D) D[int'(cnt)*WORD_LEN +: WORD_LEN] <= in_data;
      else W[int'(cnt)*WORD_LEN +: WORD_LEN] <= in_data;
      if (first) mode <= mode_in;
    end
endmodule

// File: tb/tb_pe_feeder.sv
// tb_pe_feeder: scoreboard bench for pe_feeder framing, stalls, reset abort, mode capture and fire timing
module tb_pe_feeder;
  localparam int WL = 16, NI = 8, NO = 4, NW = NI * NO;
  typedef struct { logic [WL*NI-1:0] d; logic [WL*NW-1:0] w; logic [1:0] m; int fire; } exp_t;
  logic clk = 0, rst = 1, in_valid = 0, in_ready, ce, q_valid;
`ifdef PE_FEEDER_WEIGHT_REUSE_EN
  logic weight_keep = 0;
`endif
  logic [WL-1:0] in_data = '0;
  logic [1:0] mode_in = 2'b01, mode;
  logic [WL*NI-1:0] D, d_model = '0;
  logic [WL*NW-1:0] W, w_model = '0;
  int checks = 0, errors = 0, cyc = 0, ce_cnt = 0;
  exp_t sb[$];

  pe_feeder #(.WORD_LEN(WL), .NEU_IN(NI), .NEU_OUT(NO)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .mode_in(mode_in),
`ifdef PE_FEEDER_WEIGHT_REUSE_EN
    .weight_keep(weight_keep),
`endif
    .D(D),
    .W(W),
    .ce(ce),
    .mode(mode),
    .q_valid(q_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ce) ce_cnt <= ce_cnt + 1;
  end

  task automatic send(input logic [WL-1:0] v, input logic [1:0] m, output int t);
    int n = 0;
    in_valid = 1; in_data = v; mode_in = m;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    in_valid = 0;
    t = n < 100 ? cyc : -1;
  endtask

  task automatic drive_words(input int base, input int k0, input int n, input logic [1:0] m0, input logic [1:0] mr, output int t0);
    int t;
    t0 = -1;
    for (int k = k0; k < k0 + n; k++) begin
      send(WL'(base + k), k == 0 ? m0 : mr, t);
      checks++;
      if (t < 0) begin errors++; $display("FAIL send_timeout word=%0d in_ready=%b required=1", k, in_ready); end
      if (k == k0) t0 = t;
      if (k < NI) d_model[k*WL +: WL] = WL'(base + k);
      else w_model[(k-NI)*WL +: WL] = WL'(base + k);
    end
  endtask

  task automatic wait_ce(output int c);
    c = -1;
    for (int n = 0; n < 200; n++) begin
      if (ce === 1'b1) begin c = cyc; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (2) @(negedge clk);
    checks++;
    if (D !== '0 || W !== '0 || mode !== 2'b01 || ce !== 1'b0 || q_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_state D=%h mode=%b ce=%b q_valid=%b in_ready=%b required 0/01/0/0/0", D, mode, ce, q_valid, in_ready);
    end
    rst = 0;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_idle in_ready=%b required=0", in_ready); end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_to_load_d in_ready=%b required=1", in_ready); end
  endtask

  task automatic test_basic;
    int t0, c, ce0;
    exp_t e;
    ce0 = ce_cnt;
    drive_words(1, 0, NI + NW, 2'b01, 2'b01, t0);
    sb.push_back('{d_model, w_model, 2'b01, t0 + NI + NW - 1});
    wait_ce(c);
    e = sb.pop_front();
    checks++;
    if (c != e.fire) begin errors++; $display("FAIL basic_ce_cycle got=%0d exp=%0d", c, e.fire); end
    checks++;
    if (D !== e.d || W !== e.w || mode !== e.m) begin
      errors++; $display("FAIL basic_data D=%h W=%h mode=%b exp D=%h W=%h mode=%b", D, W, mode, e.d, e.w, e.m);
    end
    checks++;
    if (D[WL-1:0] !== 16'd1 || W[WL*NW-1 -: WL] !== 16'd40) begin
      errors++; $display("FAIL basic_words d0=%0d w31=%0d exp 1/40", D[WL-1:0], W[WL*NW-1 -: WL]);
    end
    @(negedge clk);
    checks++;
    if (q_valid !== 1'b1 || ce !== 1'b0 || cyc - t0 + 2 != 42) begin
      errors++; $display("FAIL basic_q_valid q_valid=%b ce=%b cycle=%0d exp 1/0/42", q_valid, ce, cyc - t0 + 2);
    end
    checks++;
    if (ce_cnt != ce0 + 1) begin errors++; $display("FAIL basic_ce_count got=%0d exp=%0d", ce_cnt - ce0, 1); end
  endtask

  task automatic test_stall;
    int t0, t1, c, ce0;
    logic [WL*NW-1:0] snap;
    exp_t e;
    ce0 = ce_cnt;
    drive_words(100, 0, 20, 2'b01, 2'b01, t0);
    snap = W;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (in_ready !== 1'b1 || ce !== 1'b0 || W !== snap) begin
        errors++; $display("FAIL stall_hold cycle=%0d in_ready=%b ce=%b W=%h exp 1/0/%h", i, in_ready, ce, W, snap);
      end
      @(negedge clk);
    end
    drive_words(100, 20, 20, 2'b01, 2'b01, t1);
    sb.push_back('{d_model, w_model, 2'b01, t0 + NI + NW - 1 + 5});
    wait_ce(c);
    e = sb.pop_front();
    checks++;
    if (c != e.fire) begin errors++; $display("FAIL stall_ce_cycle got=%0d exp=%0d", c, e.fire); end
    checks++;
    if (D !== e.d || W !== e.w || mode !== e.m) begin
      errors++; $display("FAIL stall_data D=%h W=%h exp D=%h W=%h", D, W, e.d, e.w);
    end
    @(negedge clk);
    checks++;
    if (ce_cnt != ce0 + 1) begin errors++; $display("FAIL stall_ce_count got=%0d exp=%0d", ce_cnt - ce0, 1); end
  endtask

  task automatic test_fire_hold;
    int t0, t1, c, ce0;
    logic [WL*NI-1:0] snap_d;
    exp_t e;
    ce0 = ce_cnt;
    drive_words(200, 0, NI + NW, 2'b01, 2'b01, t0);
    sb.push_back('{d_model, w_model, 2'b01, t0 + NI + NW - 1});
    wait_ce(c);
    e = sb.pop_front();
    in_valid = 1; in_data = 16'hBEEF; mode_in = 2'b01;
    checks++;
    if (c != e.fire || in_ready !== 1'b0) begin
      errors++; $display("FAIL hold_fire cycle=%0d in_ready=%b exp %0d/0", c, in_ready, e.fire);
    end
    checks++;
    if (D !== e.d || W !== e.w) begin errors++; $display("FAIL hold_data D=%h W=%h exp D=%h W=%h", D, W, e.d, e.w); end
    snap_d = D;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || q_valid !== 1'b1 || D !== snap_d) begin
      errors++; $display("FAIL hold_settle in_ready=%b q_valid=%b D=%h exp 0/1/%h", in_ready, q_valid, D, snap_d);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || D !== snap_d) begin
      errors++; $display("FAIL hold_no_consume in_ready=%b D=%h exp 1/%h", in_ready, D, snap_d);
    end
    @(negedge clk);
    in_valid = 0;
    t0 = cyc;
    d_model[WL-1:0] = 16'hBEEF;
    checks++;
    if (D[WL-1:0] !== 16'hBEEF || D[2*WL-1:WL] !== snap_d[2*WL-1:WL]) begin
      errors++; $display("FAIL hold_first_word d0=%h d1=%h exp beef/%h", D[WL-1:0], D[2*WL-1:WL], snap_d[2*WL-1:WL]);
    end
    drive_words(300, 1, NI + NW - 1, 2'b01, 2'b01, t1);
    sb.push_back('{d_model, w_model, 2'b01, t0 + NI + NW - 1});
    wait_ce(c);
    e = sb.pop_front();
    checks++;
    if (c != e.fire) begin errors++; $display("FAIL hold_next_ce_cycle got=%0d exp=%0d", c, e.fire); end
    checks++;
    if (D !== e.d || W !== e.w) begin errors++; $display("FAIL hold_next_data D=%h W=%h exp D=%h W=%h", D, W, e.d, e.w); end
    @(negedge clk);
    checks++;
    if (ce_cnt != ce0 + 2) begin errors++; $display("FAIL hold_ce_count got=%0d exp=%0d", ce_cnt - ce0, 2); end
  endtask

  task automatic test_mode;
    int t0, t1, c;
    exp_t e;
    drive_words(500, 0, 1, 2'b00, 2'b11, t0);
    checks++;
    if (mode !== 2'b00) begin errors++; $display("FAIL mode_first got=%b exp=00", mode); end
    drive_words(500, 1, 20, 2'b00, 2'b11, t1);
    checks++;
    if (mode !== 2'b00) begin errors++; $display("FAIL mode_mid got=%b exp=00", mode); end
    drive_words(500, 21, NI + NW - 21, 2'b00, 2'b11, t1);
    sb.push_back('{d_model, w_model, 2'b00, t0 + NI + NW - 1});
    wait_ce(c);
    e = sb.pop_front();
    checks++;
    if (c != e.fire || mode !== e.m) begin errors++; $display("FAIL mode_fire cycle=%0d mode=%b exp %0d/%b", c, mode, e.fire, e.m); end
    checks++;
    if (D !== e.d || W !== e.w) begin errors++; $display("FAIL mode_data D=%h W=%h exp D=%h W=%h", D, W, e.d, e.w); end
    @(negedge clk);
    checks++;
    if (mode !== 2'b00 || q_valid !== 1'b1) begin errors++; $display("FAIL mode_settle mode=%b q_valid=%b exp 00/1", mode, q_valid); end
  endtask

  task automatic test_reset_mid;
    int t0, c, ce0;
    exp_t e;
    ce0 = ce_cnt;
    drive_words(700, 0, 20, 2'b01, 2'b01, t0);
    #2 rst = 1;
    #1;
    checks++;
    if (D !== '0 || W !== '0 || mode !== 2'b01 || in_ready !== 1'b0 || ce !== 1'b0) begin
      errors++; $display("FAIL reset_async D=%h mode=%b in_ready=%b ce=%b exp 0/01/0/0", D, mode, in_ready, ce);
    end
    d_model = '0;
    w_model = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (D !== '0 || W !== '0 || ce_cnt != ce0) begin
      errors++; $display("FAIL reset_hold D=%h ce_pulses=%0d exp 0/0", D, ce_cnt - ce0);
    end
    rst = 0;
    drive_words(800, 0, NI + NW, 2'b01, 2'b01, t0);
    sb.push_back('{d_model, w_model, 2'b01, t0 + NI + NW - 1});
    wait_ce(c);
    e = sb.pop_front();
    checks++;
    if (c != e.fire) begin errors++; $display("FAIL reset_new_ce_cycle got=%0d exp=%0d", c, e.fire); end
    checks++;
    if (D !== e.d || W !== e.w || mode !== e.m) begin errors++; $display("FAIL reset_new_data D=%h W=%h exp D=%h W=%h", D, W, e.d, e.w); end
    @(negedge clk);
    checks++;
    if (ce_cnt != ce0 + 1) begin errors++; $display("FAIL reset_ce_count got=%0d exp=%0d", ce_cnt - ce0, 1); end
  endtask

`ifdef PE_FEEDER_WEIGHT_REUSE_EN
  task automatic test_weight_reuse;
    int t0, c, ce0;
    exp_t e;
    ce0 = ce_cnt;
    weight_keep = 0;
    drive_words(900, 0, NI + NW, 2'b01, 2'b01, t0);
    sb.push_back('{d_model, w_model, 2'b01, t0 + NI + NW - 1});
    wait_ce(c);
    e = sb.pop_front();
    checks++;
    if (c != e.fire || W !== e.w) begin errors++; $display("FAIL reuse_full cycle=%0d W=%h exp %0d/%h", c, W, e.fire, e.w); end
    weight_keep = 1;
    drive_words(1000, 0, NI, 2'b01, 2'b01, t0);
    weight_keep = 0;
    sb.push_back('{d_model, w_model, 2'b01, t0 + NI - 1});
    wait_ce(c);
    e = sb.pop_front();
    checks++;
    if (c != e.fire) begin errors++; $display("FAIL reuse_ce_cycle got=%0d exp=%0d", c, e.fire); end
    checks++;
    if (D !== e.d || W !== e.w) begin errors++; $display("FAIL reuse_data D=%h W=%h exp D=%h W=%h", D, W, e.d, e.w); end
    @(negedge clk);
    checks++;
    if (ce_cnt != ce0 + 2) begin errors++; $display("FAIL reuse_ce_count got=%0d exp=%0d", ce_cnt - ce0, 2); end
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_stall;
    test_fire_hold;
    test_mode;
    test_reset_mid;
`ifdef PE_FEEDER_WEIGHT_REUSE_EN
    test_weight_reuse;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
    $finish;
  end
endmodule
